// File: rtl/cursor_field_ctrl.sv
// Cursor/field-enable controller for a clock-setting UI: a group is latched on edit entry and a cursor walks its fields.
// Optional idle auto-exit is compiled in with `define CURSOR_TIMEOUT_EN.
module cursor_field_ctrl #(
   parameter int N_FIELDS      = 3,
   parameter int N_GROUPS      = 3,
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_GROUPS-1:0]          group_sel,
   input  logic                         edit_req,
   input  logic                         edit_exit,
   input  logic                         btn_left,
   input  logic                         btn_right,
   input  logic                         tick,
   output logic [((N_FIELDS > 1) ? $clog2(N_FIELDS) : 1)-1:0] dir_bin,
   output logic                         editing,
   output logic [N_GROUPS*N_FIELDS-1:0] en_field,
   output logic [N_GROUPS-1:0]          grp_lat
);

   localparam int CW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
   localparam logic [CW-1:0] DIR_ONE = CW'(1);
   localparam logic [CW-1:0] DIR_MAX = CW'(N_FIELDS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         dir_q, dir_d;
   logic [N_GROUPS-1:0]   grp_q, grp_d;
   logic                  editing_q, editing_d;
   logic                  timeout_s;

`ifdef CURSOR_TIMEOUT_EN
   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_TICKS - 1);
   logic [TW-1:0]         cnt_q, cnt_d;
`else
   logic                  tick_unused;
   assign tick_unused = tick;
`endif

   function automatic logic is_one_hot(input logic [N_GROUPS-1:0] v);
      return (v != {N_GROUPS{1'b0}}) && ((v & (v - N_GROUPS'(1))) == {N_GROUPS{1'b0}});
   endfunction

   // Next-state logic: entry, exit (explicit or timeout) and cursor movement
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      grp_d     = grp_q;
      timeout_s = 1'b0;
`ifdef CURSOR_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (edit_req && is_one_hot(group_sel)) begin
               state_d = EDIT;
               grp_d   = group_sel;
               dir_d   = {CW{1'b0}};
`ifdef CURSOR_TIMEOUT_EN
               cnt_d   = {TW{1'b0}};
`endif
            end else begin
               state_d = IDLE;
            end
         end
         EDIT: begin
`ifdef CURSOR_TIMEOUT_EN
            // A button in the same cycle as a tick wins: clear, never expire
            if (btn_left || btn_right) begin
               cnt_d = {TW{1'b0}};
            end else if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  timeout_s = 1'b1;
               end else begin
                  cnt_d = cnt_q + TW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
`endif
            if (edit_exit || timeout_s) begin
               state_d = IDLE;
               grp_d   = {N_GROUPS{1'b0}};
               dir_d   = {CW{1'b0}};
`ifdef CURSOR_TIMEOUT_EN
               cnt_d   = {TW{1'b0}};
`endif
            end else if (btn_right && !btn_left) begin
               dir_d = (dir_q == DIR_MAX) ? {CW{1'b0}} : dir_q + DIR_ONE;
            end else if (btn_left && !btn_right) begin
               dir_d = (dir_q == {CW{1'b0}}) ? DIR_MAX : dir_q - DIR_ONE;
            end else begin
               dir_d = dir_q;
            end
         end
         default: begin
            state_d = IDLE;
            grp_d   = {N_GROUPS{1'b0}};
            dir_d   = {CW{1'b0}};
         end
      endcase
      editing_d = (state_d == EDIT);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_q     <= {CW{1'b0}};
         grp_q     <= {N_GROUPS{1'b0}};
         editing_q <= 1'b0;
`ifdef CURSOR_TIMEOUT_EN
         cnt_q     <= {TW{1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         grp_q     <= grp_d;
         editing_q <= editing_d;
`ifdef CURSOR_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Field enable decode: only the cursor field of the latched group can be high
   always_comb begin
      en_field = {(N_GROUPS*N_FIELDS){1'b0}};
      for (int g = 0; g < N_GROUPS; g++) begin
         for (int f = 0; f < N_FIELDS; f++) begin
            if (dir_q == CW'(f)) begin
               en_field[g*N_FIELDS+f] = editing_q & grp_q[g];
            end else begin
               en_field[g*N_FIELDS+f] = 1'b0;
            end
         end
      end
   end

   assign dir_bin = dir_q;
   assign editing = editing_q;
   assign grp_lat = grp_q;

endmodule
